rx_gmii_framer: RTL and testbench



---
 rtl/tse_rx_pkg.sv | 21 ++
 rtl/crc32_d8.sv | 23 ++
 rtl/rx_gmii_framer.sv | 168 ++++++++++++++++
 tb/tb_rx_gmii_framer.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/tse_rx_pkg.sv
// Shared constants and state encoding for the TSE receive front end.
package tse_rx_pkg;

  localparam logic [7:0]  PREAMBLE_BYTE = 8'h55;
  localparam logic [7:0]  SFD_BYTE      = 8'hD5;
  localparam logic [31:0] CRC_INIT      = 32'hFFFF_FFFF;
  localparam logic [31:0] CRC_POLY      = 32'h04C1_1DB7;
  // Register value left behind after clocking a good frame through, FCS included.
  localparam logic [31:0] CRC_RESIDUE   = 32'hC704_DD7B;

  localparam int          CNT_W         = 14;
  localparam logic [13:0] CNT_MAX       = 14'h3FFF;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    PREAMBLE = 2'd1,
    DATA     = 2'd2,
    DROP     = 2'd3
  } rx_state_e;

endpackage

// File: rtl/crc32_d8.sv
// Combinational CRC-32 step over one byte. The register is kept MSB-first
// while the data byte is consumed LSB-first, which is the Ethernet bit order;
// a good frame therefore leaves CRC_RESIDUE in the register.
module crc32_d8
  import tse_rx_pkg::*;
(
  input  logic [31:0] crc_i,
  input  logic [7:0]  data_i,
  output logic [31:0] crc_o
);

  // Eight serial shift/xor steps unrolled into one combinational cone.
  always_comb begin
    logic [31:0] c;
    c = crc_i;
    for (int i = 0; i < 8; i++) begin
      if (c[31] ^ data_i[i]) c = {c[30:0], 1'b0} ^ CRC_POLY;
      else                   c = {c[30:0], 1'b0};
    end
    crc_o = c;
  end

endmodule

// File: rtl/rx_gmii_framer.sv
// GMII/MII receive framer: strips preamble/SFD, delivers frame bytes with
// SOF/EOF markers and reports CRC, code-error and length status at EOF.
// Every register advances only on the byte strobe clk_en.
//
// Handshake: there is no back-pressure. A consumer takes rx_data whenever
// rx_valid=1 on a cycle with clk_en=1; rx_eof and the status outputs are
// likewise qualified by clk_en. rx_valid and rx_eof are never high together.
module rx_gmii_framer
  import tse_rx_pkg::*;
#(
  parameter int DLY     = 1,
  parameter int MIN_LEN = 64,
  parameter int MAX_LEN = 1518
) (
  input  logic             CORETSE_AHBii0,
  input  logic             CORETSE_AHBl0II,
  input  logic             clk_en,
  input  logic [7:0]       gmii_rxd,
  input  logic             gmii_rx_dv,
  input  logic             gmii_rx_er,
  output logic [7:0]       rx_data,
  output logic             rx_valid,
  output logic             rx_sof,
  output logic             rx_eof,
  output logic             rx_crc_err,
  output logic             rx_code_err,
  output logic             rx_short,
  output logic             rx_long,
  output logic [CNT_W-1:0] rx_byte_cnt
);

  // Registers here are zero-delay; DLY is kept only so existing instantiations
  // that override it still elaborate.
  logic [31:0] dly_unused;
  assign dly_unused = DLY;

  rx_state_e        state_q, state_d;
  logic [31:0]      crc_q, crc_d, crc_next;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             code_err_q, code_err_d;

  logic [7:0]       data_q, data_d;
  logic             valid_q, valid_d;
  logic             sof_q, sof_d;
  logic             eof_q, eof_d;
  logic             crc_err_q, crc_err_d;
  logic             code_o_q, code_o_d;
  logic             short_q, short_d;
  logic             long_q, long_d;
  logic [CNT_W-1:0] byte_cnt_q, byte_cnt_d;

  crc32_d8 u_crc (
    .crc_i  (crc_q),
    .data_i (gmii_rxd),
    .crc_o  (crc_next)
  );

  // State register, advanced on the byte strobe only.
  always_ff @(posedge CORETSE_AHBii0 or posedge CORETSE_AHBl0II) begin
    if (CORETSE_AHBl0II)  state_q <= IDLE;
    else if (clk_en)      state_q <= state_d;
  end

  // Next-state logic: only a clean 0x55...0xD5 run reaches DATA.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (gmii_rx_dv) state_d = (gmii_rxd == PREAMBLE_BYTE) ? PREAMBLE : DROP;
      end
      PREAMBLE: begin
        if (!gmii_rx_dv)                  state_d = IDLE;
        else if (gmii_rxd == SFD_BYTE)    state_d = DATA;
        else if (gmii_rxd != PREAMBLE_BYTE) state_d = DROP;
      end
      DATA: begin
        if (!gmii_rx_dv) state_d = IDLE;
      end
      DROP: begin
        if (!gmii_rx_dv) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Output and datapath next values; pulses default low, status holds.
  always_comb begin
    crc_d      = crc_q;
    cnt_d      = cnt_q;
    code_err_d = code_err_q;
    data_d     = data_q;
    valid_d    = 1'b0;
    sof_d      = 1'b0;
    eof_d      = 1'b0;
    crc_err_d  = crc_err_q;
    code_o_d   = code_o_q;
    short_d    = short_q;
    long_d     = long_q;
    byte_cnt_d = byte_cnt_q;

    if (state_q == PREAMBLE && gmii_rx_dv && gmii_rxd == SFD_BYTE) begin
      crc_d      = CRC_INIT;
      cnt_d      = '0;
      code_err_d = 1'b0;
    end

    if (state_q == DATA) begin
      if (gmii_rx_dv) begin
        data_d     = gmii_rxd;
        valid_d    = 1'b1;
        // The counter saturates, so it is zero only before the first byte.
        sof_d      = (cnt_q == '0);
        crc_d      = crc_next;
        cnt_d      = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
        code_err_d = code_err_q | gmii_rx_er;
      end else begin
        eof_d      = 1'b1;
        crc_err_d  = (crc_q != CRC_RESIDUE);
        code_o_d   = code_err_q;
        short_d    = (int'(cnt_q) < MIN_LEN);
        long_d     = (int'(cnt_q) > MAX_LEN);
        byte_cnt_d = cnt_q;
      end
    end
  end

  // Datapath and output registers, advanced on the byte strobe only.
  always_ff @(posedge CORETSE_AHBii0 or posedge CORETSE_AHBl0II) begin
    if (CORETSE_AHBl0II) begin
      crc_q      <= CRC_INIT;
      cnt_q      <= '0;
      code_err_q <= 1'b0;
      data_q     <= '0;
      valid_q    <= 1'b0;
      sof_q      <= 1'b0;
      eof_q      <= 1'b0;
      crc_err_q  <= 1'b0;
      code_o_q   <= 1'b0;
      short_q    <= 1'b0;
      long_q     <= 1'b0;
      byte_cnt_q <= '0;
    end else if (clk_en) begin
      crc_q      <= crc_d;
      cnt_q      <= cnt_d;
      code_err_q <= code_err_d;
      data_q     <= data_d;
      valid_q    <= valid_d;
      sof_q      <= sof_d;
      eof_q      <= eof_d;
      crc_err_q  <= crc_err_d;
      code_o_q   <= code_o_d;
      short_q    <= short_d;
      long_q     <= long_d;
      byte_cnt_q <= byte_cnt_d;
    end
  end

  assign rx_data     = data_q;
  assign rx_valid    = valid_q;
  assign rx_sof      = sof_q;
  assign rx_eof      = eof_q;
  assign rx_crc_err  = crc_err_q;
  assign rx_code_err = code_o_q;
  assign rx_short    = short_q;
  assign rx_long     = long_q;
  assign rx_byte_cnt = byte_cnt_q;

endmodule

// File: tb/tb_rx_gmii_framer.sv
// Directed bench for rx_gmii_framer: frames are built with a software CRC,
// driven byte by byte, and the captured output stream is compared per frame.
module tb_rx_gmii_framer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        clk_en = 1'b0;
  logic [7:0]  gmii_rxd = 8'h00;
  logic        gmii_rx_dv = 1'b0;
  logic        gmii_rx_er = 1'b0;
  logic [7:0]  rx_data;
  logic        rx_valid, rx_sof, rx_eof;
  logic        rx_crc_err, rx_code_err, rx_short, rx_long;
  logic [13:0] rx_byte_cnt;

  rx_gmii_framer #(.DLY(1), .MIN_LEN(64), .MAX_LEN(1518)) dut (
    .CORETSE_AHBii0  (clk),
    .CORETSE_AHBl0II (rst),
    .clk_en          (clk_en),
    .gmii_rxd        (gmii_rxd),
    .gmii_rx_dv      (gmii_rx_dv),
    .gmii_rx_er      (gmii_rx_er),
    .rx_data         (rx_data),
    .rx_valid        (rx_valid),
    .rx_sof          (rx_sof),
    .rx_eof          (rx_eof),
    .rx_crc_err      (rx_crc_err),
    .rx_code_err     (rx_code_err),
    .rx_short        (rx_short),
    .rx_long         (rx_long),
    .rx_byte_cnt     (rx_byte_cnt)
  );

  // Clock and reset block
  always #5 clk = ~clk;

  int          vectors = 0;
  int          miscompares = 0;

  // Scoreboard: expected frame bytes and captured output stream
  logic [7:0]  exp_q[$];
  logic [7:0]  got_q[$];
  int          sidx, valid_cnt, sof_cnt, eof_cnt, overlap_cnt, hold_viol;
  int          first_valid_idx, last_valid_idx, sof_idx, eof_idx;
  logic [7:0]  sof_data;
  logic [3:0]  st_flags;
  logic [13:0] st_cnt;
  bit          mii_mode = 1'b0;
  logic [28:0] last_bundle;

  function automatic logic [28:0] bundle();
    return {rx_data, rx_valid, rx_sof, rx_eof, rx_crc_err, rx_code_err,
            rx_short, rx_long, rx_byte_cnt};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_mon();
    got_q.delete();
    valid_cnt = 0; sof_cnt = 0; eof_cnt = 0; overlap_cnt = 0;
    first_valid_idx = -1; last_valid_idx = -1; sof_idx = -2; eof_idx = -2;
    sof_data = 8'h00; st_flags = 4'hF; st_cnt = 14'h3FFF;
  endtask

  task automatic sample();
    sidx++;
    last_bundle = bundle();
    if (rx_valid) begin
      got_q.push_back(rx_data);
      if (valid_cnt == 0) first_valid_idx = sidx;
      last_valid_idx = sidx;
      valid_cnt++;
    end
    if (rx_sof) begin
      if (sof_cnt == 0) begin sof_idx = sidx; sof_data = rx_data; end
      sof_cnt++;
    end
    if (rx_eof) begin
      eof_cnt++;
      eof_idx = sidx;
      st_flags = {rx_crc_err, rx_code_err, rx_short, rx_long};
      st_cnt = rx_byte_cnt;
      if (rx_valid) overlap_cnt++;
    end
  endtask

  // Driver: one byte strobe; in MII mode a non-strobe clock precedes it.
  task automatic step(input logic [7:0] d, input logic dv, input logic er);
    gmii_rxd = d; gmii_rx_dv = dv; gmii_rx_er = er;
    if (mii_mode) begin
      clk_en = 1'b0;
      @(posedge clk); #1;
      if (bundle() !== last_bundle) hold_viol++;
    end
    clk_en = 1'b1;
    @(posedge clk); #1;
    sample();
  endtask

  // Append DA..payload of n-4 bytes plus FCS (reflected software CRC-32).
  function automatic void build_frame(input int n, input int seed, input bit flip);
    int base;
    logic [31:0] c;
    logic [7:0] b;
    base = exp_q.size();
    for (int i = 0; i < n - 4; i++) begin
      b = (i == 0) ? 8'hA5 : 8'(i * 7 + seed);
      exp_q.push_back(b);
    end
    c = 32'hFFFF_FFFF;
    for (int i = base; i < base + n - 4; i++) begin
      c = c ^ {24'h0, exp_q[i]};
      for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
    end
    c = ~c;
    if (flip) c[0] = ~c[0];
    exp_q.push_back(c[7:0]);
    exp_q.push_back(c[15:8]);
    exp_q.push_back(c[23:16]);
    exp_q.push_back(c[31:24]);
  endfunction

  task automatic send_frame(input int first, input int n, input int er_idx, input int idle);
    repeat (7) step(8'h55, 1'b1, 1'b0);
    step(8'hD5, 1'b1, 1'b0);
    for (int i = 0; i < n; i++) step(exp_q[first + i], 1'b1, (i == er_idx));
    repeat (idle) step(8'h00, 1'b0, 1'b0);
  endtask

  // flags = {crc_err, code_err, short, long}
  task automatic check_frame(input string tag, input int n_bytes, input int n_eof,
                             input logic [3:0] flags, input logic [13:0] cnt);
    int mism;
    mism = 0;
    chk({tag, "_bytes"}, valid_cnt, n_bytes);
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
      if (got_q[i] !== exp_q[i]) mism++;
    chk({tag, "_data"}, mism, 0);
    chk({tag, "_eof_cnt"}, eof_cnt, n_eof);
    chk({tag, "_valid_on_eof"}, overlap_cnt, 0);
    chk({tag, "_flags"}, 32'(st_flags), 32'(flags));
    chk({tag, "_cnt"}, 32'(st_cnt), 32'(cnt));
    if (n_bytes > 0) begin
      chk({tag, "_sof_cnt"}, sof_cnt, n_eof);
      chk({tag, "_sof_data"}, 32'(sof_data), 32'(exp_q[0]));
      chk({tag, "_sof_pos"}, sof_idx, first_valid_idx);
      chk({tag, "_eof_lat"}, eof_idx - last_valid_idx, 1);
    end else begin
      chk({tag, "_sof_cnt"}, sof_cnt, 0);
    end
  endtask

  initial begin
    sidx = 0; hold_viol = 0;
    clear_mon();

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outputs", 32'(bundle()), 32'h0);
    rst = 1'b0;
    last_bundle = bundle();

    // Good 64-byte frame
    exp_q.delete(); build_frame(64, 3, 1'b0); clear_mon();
    send_frame(0, 64, -1, 2);
    check_frame("good64", 64, 1, 4'b0000, 14'd64);

    // Same frame, FCS bit 0 flipped
    exp_q.delete(); build_frame(64, 3, 1'b1); clear_mon();
    send_frame(0, 64, -1, 2);
    check_frame("badfcs", 64, 1, 4'b1000, 14'd64);

    // rx_er on byte 10, then a clean frame clears code_err
    exp_q.delete(); build_frame(64, 11, 1'b0); clear_mon();
    send_frame(0, 64, 10, 2);
    check_frame("code_err", 64, 1, 4'b0100, 14'd64);
    clear_mon();
    send_frame(0, 64, -1, 2);
    check_frame("code_clr", 64, 1, 4'b0000, 14'd64);

    // Junk: bad first byte, 0x55 then 0x12, bare SFD, false carrier
    clear_mon();
    repeat (4) step(8'h00, 1'b1, 1'b0);
    step(8'h00, 1'b0, 1'b0);
    step(8'h55, 1'b1, 1'b0); step(8'h12, 1'b1, 1'b0);
    repeat (3) step(8'h55, 1'b1, 1'b0);
    step(8'hD5, 1'b1, 1'b0); step(8'h11, 1'b1, 1'b0);
    step(8'h00, 1'b0, 1'b0);
    step(8'hD5, 1'b1, 1'b0); step(8'h22, 1'b1, 1'b0);
    step(8'h00, 1'b0, 1'b0);
    step(8'h0E, 1'b0, 1'b1); step(8'h0E, 1'b0, 1'b1);
    step(8'h00, 1'b0, 1'b0);
    chk("junk_valid", valid_cnt, 0);
    chk("junk_eof", eof_cnt, 0);

    // Short frames and length boundaries
    exp_q.delete(); build_frame(40, 5, 1'b0); clear_mon();
    send_frame(0, 40, -1, 2);
    check_frame("short40", 40, 1, 4'b0010, 14'd40);
    exp_q.delete(); build_frame(63, 9, 1'b0); clear_mon();
    send_frame(0, 63, -1, 2);
    check_frame("short63", 63, 1, 4'b0010, 14'd63);
    exp_q.delete(); build_frame(1518, 2, 1'b0); clear_mon();
    send_frame(0, 1518, -1, 2);
    check_frame("max1518", 1518, 1, 4'b0000, 14'd1518);
    exp_q.delete(); build_frame(1519, 4, 1'b0); clear_mon();
    send_frame(0, 1519, -1, 2);
    check_frame("long1519", 1519, 1, 4'b0001, 14'd1519);

    // Empty frame: SFD then rx_dv low
    exp_q.delete(); clear_mon();
    repeat (7) step(8'h55, 1'b1, 1'b0);
    step(8'hD5, 1'b1, 1'b0);
    step(8'h00, 1'b0, 1'b0); step(8'h00, 1'b0, 1'b0);
    check_frame("empty", 0, 1, 4'b1010, 14'd0);

    // Back-to-back frames with a single idle strobe
    exp_q.delete(); build_frame(64, 21, 1'b0); build_frame(64, 33, 1'b0); clear_mon();
    send_frame(0, 64, -1, 1);
    send_frame(64, 64, -1, 2);
    check_frame("b2b", 128, 2, 4'b0000, 14'd64);

    // MII pacing: strobe every second clock, outputs hold in between
    exp_q.delete(); build_frame(64, 3, 1'b0); clear_mon();
    mii_mode = 1'b1; hold_viol = 0;
    send_frame(0, 64, -1, 2);
    mii_mode = 1'b0;
    check_frame("mii64", 64, 1, 4'b0000, 14'd64);
    chk("mii_hold", hold_viol, 0);

    // Reset at byte 30, release with rx_dv still high, then a good frame
    exp_q.delete(); build_frame(64, 7, 1'b0); clear_mon();
    repeat (7) step(8'h55, 1'b1, 1'b0);
    step(8'hD5, 1'b1, 1'b0);
    for (int i = 0; i < 30; i++) step(exp_q[i], 1'b1, 1'b0);
    chk("pre_rst_valid", 32'(rx_valid), 32'h1);
    rst = 1'b1;
    #1;
    chk("rst_mid_outputs", 32'(bundle()), 32'h0);
    gmii_rxd = 8'h3C; gmii_rx_dv = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    last_bundle = bundle();
    clear_mon();
    repeat (10) step(8'h3C, 1'b1, 1'b0);
    step(8'h00, 1'b0, 1'b0);
    chk("drop_valid", valid_cnt, 0);
    chk("drop_eof", eof_cnt, 0);
    clear_mon();
    send_frame(0, 64, -1, 2);
    check_frame("after_rst", 64, 1, 4'b0000, 14'd64);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
